// File: rtl/mux_arbiter_if.sv
// Bus bundle for mux_arbiter: two requester ports (A, B) and the single
// registered output port with ready/valid handshake.
interface mux_arbiter_if #(
    parameter int WIDTH = 8
) ();
    logic             a_req;
    logic [WIDTH-1:0] a_data;
    logic             a_last;
    logic             a_gnt;
    logic             b_req;
    logic [WIDTH-1:0] b_data;
    logic             b_last;
    logic             b_gnt;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_last;
    logic             out_ready;
    logic             busy;
    logic             timeout_evt;

    modport slave (
        input  a_req, a_data, a_last, b_req, b_data, b_last, out_ready,
        output a_gnt, b_gnt, out_valid, out_data, out_src, out_last, busy, timeout_evt
    );

    modport master (
        output a_req, a_data, a_last, b_req, b_data, b_last, out_ready,
        input  a_gnt, b_gnt, out_valid, out_data, out_src, out_last, busy, timeout_evt
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-requester packet mux with round-robin arbitration and a single-entry
// registered output stage. Packets are atomic: a grant is held until the
// requester's last beat is accepted.
// Optional feature macro: ARB_TIMEOUT_EN -- when defined, a grant is forcibly
// released after MAX_HOLD beats if the other requester is waiting; the
// preempted requester resumes its packet on its next grant.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no owner; arbitration happens here
// GNT_A | requester A owns the mux until its last beat
// GNT_B | requester B owns the mux until its last beat
module mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("mux_arbiter: MAX_HOLD must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic             last_win_a;
    logic             accept;
    logic             beat_acc;
    logic             beat_last;
    logic             force_rel;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_src_q;
    logic             out_last_q;

    // Beat acceptance: only the granted requester can load the output register.
    always_comb begin
        accept    = ~out_valid_q | bus.out_ready;
        beat_acc  = 1'b0;
        beat_last = 1'b0;
        case (state)
            GNT_A: begin
                beat_acc  = bus.a_req & accept;
                beat_last = bus.a_last;
            end
            GNT_B: begin
                beat_acc  = bus.b_req & accept;
                beat_last = bus.b_last;
            end
            default: begin
                beat_acc  = 1'b0;
                beat_last = 1'b0;
            end
        endcase
    end

    // Next-state: round-robin in IDLE, leave a grant only on last beat or forced release.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.a_req && bus.b_req) begin
                    state_nxt = last_win_a ? GNT_B : GNT_A;
                end else if (bus.a_req) begin
                    state_nxt = GNT_A;
                end else if (bus.b_req) begin
                    state_nxt = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if ((beat_acc && beat_last) || force_rel) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Remember who finished last so the other side wins the next contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win_a <= 1'b0;
        end else if ((beat_acc && beat_last) || force_rel) begin
            last_win_a <= (state == GNT_A);
        end
    end

    // Single-entry output register; a new beat replaces a drained one without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (beat_acc) begin
            out_valid_q <= 1'b1;
            out_data_q  <= (state == GNT_A) ? bus.a_data : bus.b_data;
            out_src_q   <= (state == GNT_A);
            out_last_q  <= beat_last;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] beat_cnt;
    logic [CW:0]   cnt_sum;
    logic          other_req;
    logic          timeout_q;

    // Forced release once this grant has carried MAX_HOLD beats and the other side waits.
    always_comb begin
        other_req = 1'b0;
        if (state == GNT_A) begin
            other_req = bus.b_req;
        end else if (state == GNT_B) begin
            other_req = bus.a_req;
        end
        cnt_sum   = {1'b0, beat_cnt} + {{CW{1'b0}}, beat_acc};
        force_rel = (state != IDLE) && other_req && !(beat_acc && beat_last)
                    && (cnt_sum >= (CW+1)'(MAX_HOLD));
    end

    // Beats carried by the current grant; restarts for every new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (state == IDLE || state_nxt == IDLE) begin
            beat_cnt <= '0;
        end else if (beat_acc && beat_cnt != CW'(MAX_HOLD)) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // One-cycle pulse following a forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
        end
    end

    assign bus.timeout_evt = timeout_q;
`else
    assign force_rel       = 1'b0;
    assign bus.timeout_evt = 1'b0;
`endif

    assign bus.a_gnt     = (state == GNT_A);
    assign bus.b_gnt     = (state == GNT_B);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: a per-cycle vector table for the basic
// grant/beat timing, plus packet streams checked through per-source scoreboards.
module tb_mux_arbiter;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_arbiter_if #(.WIDTH(W)) bus ();

    mux_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Expected beats per source: {last, data}
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    logic [8:0] a_pkt[8];
    logic [8:0] b_pkt[8];

    int a_before_b;
    int first_gnt;
    int bgnt_mid_a;
    int to_pulses;

    typedef struct packed {
        logic       a_req;
        logic       b_req;
        logic       a_last;
        logic       b_last;
        logic       rdy;
        logic [7:0] a_data;
        logic [7:0] b_data;
        logic [3:0] e_ctl;   // {a_gnt, b_gnt, busy, out_valid}
        logic [7:0] e_data;
        logic       e_src;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every handshaked beat must be the next expected one of its source.
    always @(negedge clk) begin : mon
        logic [8:0] got;
        logic [8:0] want;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got = {bus.out_last, bus.out_data};
            if (bus.out_src) begin
                if (exp_a.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL beat_a_unexpected: got %0h expected none", got);
                end else begin
                    want = exp_a.pop_front();
                    chk("beat_a", 32'(got), 32'(want));
                end
            end else begin
                if (exp_b.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL beat_b_unexpected: got %0h expected none", got);
                end else begin
                    want = exp_b.pop_front();
                    chk("beat_b", 32'(got), 32'(want));
                end
            end
        end
    end

    // Drives up to two packets as well-behaved producers and records arbitration observations.
    task automatic run_stream(input int n_a, input int n_b, input int stall_start, input int stall_len);
        int   ai  = 0;
        int   bi  = 0;
        int   cyc = 0;
        logic acc_a;
        logic acc_b;
        a_before_b = -1;
        first_gnt  = 0;
        bgnt_mid_a = 0;
        to_pulses  = 0;
        for (int i = 0; i < n_a; i++) exp_a.push_back(a_pkt[i]);
        for (int i = 0; i < n_b; i++) exp_b.push_back(b_pkt[i]);
        bus.a_req     = (n_a > 0);
        bus.a_data    = a_pkt[0][7:0];
        bus.a_last    = a_pkt[0][8];
        bus.b_req     = (n_b > 0);
        bus.b_data    = b_pkt[0][7:0];
        bus.b_last    = b_pkt[0][8];
        bus.out_ready = !(stall_start == 0 && stall_len > 0);
        while ((ai < n_a || bi < n_b || bus.busy || bus.out_valid) && cyc < 200) begin
            @(negedge clk);
            acc_a = bus.a_req && bus.a_gnt && (!bus.out_valid || bus.out_ready);
            acc_b = bus.b_req && bus.b_gnt && (!bus.out_valid || bus.out_ready);
            if (first_gnt == 0) begin
                if (bus.a_gnt) first_gnt = 1;
                else if (bus.b_gnt) first_gnt = 2;
            end
            if (bus.b_gnt && a_before_b < 0) a_before_b = ai;
            if (bus.b_gnt && ai > 0 && ai < n_a) bgnt_mid_a++;
            if (bus.timeout_evt) to_pulses++;
            @(posedge clk);
            #1;
            if (acc_a) begin
                ai++;
                if (ai < n_a) begin
                    bus.a_data = a_pkt[ai][7:0];
                    bus.a_last = a_pkt[ai][8];
                end else begin
                    bus.a_req = 1'b0;
                end
            end
            if (acc_b) begin
                bi++;
                if (bi < n_b) begin
                    bus.b_data = b_pkt[bi][7:0];
                    bus.b_last = b_pkt[bi][8];
                end else begin
                    bus.b_req = 1'b0;
                end
            end
            cyc++;
            bus.out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
        end
        if (cyc >= 200) begin
            n_chk++; n_fail++;
            $display("FAIL stream_timeout: got %0d cycles expected completion", cyc);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.a_req = 0; bus.a_data = '0; bus.a_last = 0;
        bus.b_req = 0; bus.b_data = '0; bus.b_last = 0;
        bus.out_ready = 0;

        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 4'b1010, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 4'b0001, 8'h11, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h33, 4'b0110, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h33, 4'b0001, 8'h33, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h33, 4'b1010, 8'h00, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h33, 4'b0001, 8'h22, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h33, 4'b0110, 8'h00, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h33, 4'b0001, 8'h33, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0};

        // Reset values
        #22;
        chk("rst_a_gnt",     32'(bus.a_gnt),       32'd0);
        chk("rst_b_gnt",     32'(bus.b_gnt),       32'd0);
        chk("rst_busy",      32'(bus.busy),        32'd0);
        chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_out_data",  32'(bus.out_data),    32'd0);
        chk("rst_timeout",   32'(bus.timeout_evt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-beat packets: A alone, then continuous contention alternating grants
        for (int i = 0; i < 10; i++) begin
            bus.a_req     = tbl[i].a_req;
            bus.b_req     = tbl[i].b_req;
            bus.a_last    = tbl[i].a_last;
            bus.b_last    = tbl[i].b_last;
            bus.out_ready = tbl[i].rdy;
            bus.a_data    = tbl[i].a_data;
            bus.b_data    = tbl[i].b_data;
            if (tbl[i].e_ctl[0]) begin
                if (tbl[i].e_src) exp_a.push_back({1'b1, tbl[i].e_data});
                else              exp_b.push_back({1'b1, tbl[i].e_data});
            end
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ctl", i),
                32'({bus.a_gnt, bus.b_gnt, bus.busy, bus.out_valid}), 32'(tbl[i].e_ctl));
            if (tbl[i].e_ctl[0]) begin
                chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
                chk($sformatf("vec%0d_src", i),  32'(bus.out_src),  32'(tbl[i].e_src));
            end
        end

        // A 3-beat packet with a 2-cycle downstream stall while B waits
        a_pkt[0] = {1'b0, 8'h01};
        a_pkt[1] = {1'b0, 8'h02};
        a_pkt[2] = {1'b1, 8'h03};
        b_pkt[0] = {1'b1, 8'h44};
        run_stream(3, 1, 3, 2);
        chk("s3_first_gnt_a",  32'(first_gnt),  32'd1);
        chk("s3_b_gnt_mid_a",  32'(bgnt_mid_a), 32'd0);
        chk("s3_a_before_b",   32'(a_before_b), 32'd3);
        chk("s3_no_timeout",   32'(to_pulses),  32'd0);

        // A 6-beat packet against a waiting B
        for (int i = 0; i < 6; i++) a_pkt[i] = {(i == 5), 8'(8'h51 + i)};
        b_pkt[0] = {1'b1, 8'h61};
        run_stream(6, 1, 1000, 0);
        chk("s5_first_gnt_a", 32'(first_gnt), 32'd1);
`ifdef ARB_TIMEOUT_EN
        chk("s5_a_before_b",  32'(a_before_b), 32'd4);
        chk("s5_timeout_cnt", 32'(to_pulses),  32'd1);
`else
        chk("s6_a_before_b",  32'(a_before_b), 32'd6);
        chk("s6_timeout_cnt", 32'(to_pulses),  32'd0);
`endif

        // Reset while B is granted with a beat held in the output register
        bus.b_req = 1; bus.b_data = 8'h77; bus.b_last = 0;
        bus.a_req = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("s4_pre_b_gnt",     32'(bus.b_gnt),     32'd1);
        chk("s4_pre_out_valid", 32'(bus.out_valid), 32'd1);
        chk("s4_pre_out_data",  32'(bus.out_data),  32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s4_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("s4_rst_b_gnt",     32'(bus.b_gnt),     32'd0);
        chk("s4_rst_busy",      32'(bus.busy),      32'd0);
        chk("s4_rst_out_data",  32'(bus.out_data),  32'd0);
        bus.b_req = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_pkt[0] = {1'b1, 8'h81};
        b_pkt[0] = {1'b1, 8'h82};
        run_stream(1, 1, 1000, 0);
        chk("s4_first_gnt_a", 32'(first_gnt), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_a_empty", 32'(exp_a.size()), 32'd0);
        chk("sb_b_empty", 32'(exp_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
